// File: rtl/wait_state_mem_pkg.sv
// Shared types and helpers for the wait-state memory: FSM state encoding,
// wait counter width and a constant-foldable ceil(log2) helper.
package wait_state_mem_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 << i) < value) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/wait_state_mem_if.sv
// Request/response bus of the wait-state memory. The requester uses the
// master modport, the memory uses the slave modport.
interface wait_state_mem_if #(
  parameter int ADDR_W = 32,
  parameter int WIDTH  = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [ADDR_W-1:0]  req_addr;
  logic [WIDTH-1:0]   req_wdata;
  logic [WIDTH/8-1:0] req_be;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/wait_state_mem_mem_array.sv
// Storage only: byte-enable synchronous write port and combinational read
// port. Not reset, so contents survive a reset of the control logic.
module mem_array
  import wait_state_mem_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [WIDTH/8-1:0]        be,
  input  logic [clog2(WORDS)-1:0]   widx,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(WORDS)-1:0]   ridx,
  output logic [WIDTH-1:0]          rdata
);

  localparam int BYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [WORDS];

  // Byte-lane write: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (we && be[i]) begin
        mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/wait_state_mem.sv
// Synchronous word memory with byte-enable writes, programmable wait states
// and a valid/ready request/response handshake, one transaction in flight.
// Upper address bits are ignored so instances alias across address windows.
// Optional feature: define MEM_WRITE_PROTECT_EN for ROM mode, in which every
// write is answered with rsp_err=1 and the array is never written.
module wait_state_mem
  import wait_state_mem_pkg::*;
#(
  parameter int WORDS       = 256,
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  wait_state_mem_if.slave bus
);

  localparam int BYTES = WIDTH / 8;
  localparam int OFF_W = clog2(BYTES);
  localparam int IDX_W = clog2(WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  req_ready_q, req_ready_d;

  logic                  misaligned_s;
  logic                  req_err_s;
  logic [IDX_W-1:0]      req_idx_s;
  logic                  mem_we_s;
  logic [WIDTH-1:0]      mem_rdata_s;
  logic                  unused_addr_s;

  assign misaligned_s  = |(bus.req_addr & OFF_MASK);
  assign req_idx_s     = bus.req_addr[OFF_W +: IDX_W];
  assign unused_addr_s = ^bus.req_addr;

`ifdef MEM_WRITE_PROTECT_EN
  assign req_err_s = misaligned_s | bus.req_we;
`else
  assign req_err_s = misaligned_s;
`endif

  mem_array #(
    .WORDS (WORDS),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .be    (bus.req_be),
    .widx  (req_idx_s),
    .wdata (bus.req_wdata),
    .ridx  (idx_q),
    .rdata (mem_rdata_s)
  );

  // Next-state, latch and response logic; the write is committed at accept
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    err_d       = err_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d     = bus.req_we;
          err_d    = req_err_s;
          idx_d    = req_idx_s;
          cnt_d    = WAIT_LOAD;
          mem_we_s = bus.req_we & ~req_err_s;
          state_d  = HAS_WAIT ? WAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        // First RESP cycle loads the response; it is then held until taken
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (!we_q && !err_q) ? mem_rdata_s : {WIDTH{1'b0}};
          rsp_err_d   = err_q;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = {WIDTH{1'b0}};
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = {WAIT_CNT_W{1'b0}};
        rsp_valid_d = 1'b0;
        rsp_rdata_d = {WIDTH{1'b0}};
        rsp_err_d   = 1'b0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; req_ready stays low while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {WAIT_CNT_W{1'b0}};
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wait_state_mem.sv
// Directed bench for wait_state_mem: one instance with one wait state and
// one with zero wait states share the request wires; use_zw selects which
// one sees req_valid and whose outputs are observed.
module tb_wait_state_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        use_zw = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wait_state_mem_if #(.ADDR_W(32), .WIDTH(32)) ifc1 ();
  wait_state_mem_if #(.ADDR_W(32), .WIDTH(32)) ifc0 ();

  assign ifc1.req_valid = req_valid & ~use_zw;
  assign ifc1.req_we    = req_we;
  assign ifc1.req_addr  = req_addr;
  assign ifc1.req_wdata = req_wdata;
  assign ifc1.req_be    = req_be;
  assign ifc1.rsp_ready = rsp_ready;
  assign ifc0.req_valid = req_valid & use_zw;
  assign ifc0.req_we    = req_we;
  assign ifc0.req_addr  = req_addr;
  assign ifc0.req_wdata = req_wdata;
  assign ifc0.req_be    = req_be;
  assign ifc0.rsp_ready = rsp_ready;

  wire        cur_req_ready = use_zw ? ifc0.req_ready : ifc1.req_ready;
  wire        cur_rsp_valid = use_zw ? ifc0.rsp_valid : ifc1.rsp_valid;
  wire [31:0] cur_rsp_rdata = use_zw ? ifc0.rsp_rdata : ifc1.rsp_rdata;
  wire        cur_rsp_err   = use_zw ? ifc0.rsp_err   : ifc1.rsp_err;

  wait_state_mem #(.WORDS(256), .WIDTH(32), .ADDR_W(32), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc1)
  );

  wait_state_mem #(.WORDS(256), .WIDTH(32), .ADDR_W(32), .WAIT_STATES(0)) dut_zw (
    .clk(clk), .rst_n(rst_n), .bus(ifc0)
  );

  // Wait for req_ready (bounded), present one request for exactly one cycle,
  // then scribble on the request wires. Returns at the negedge after accept.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (cur_req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    if (cur_req_ready !== 1'b1) return;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_we = 1'b1; req_addr = 32'hFFFF_FFF0;
    req_wdata = ~wdata; req_be = 4'hF;
    ok = 1'b1;
  endtask

  // Count cycles from the accept edge until rsp_valid; -1 on timeout
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (cur_rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  // Full transaction with rsp_ready high; lat=-1 reports any timeout
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat);
    bit ok;
    rdata = 32'hxxxx_xxxx;
    err   = 1'bx;
    lat   = -1;
    issue(we, addr, wdata, be, ok);
    if (!ok) return;
    wait_rsp(lat);
    if (lat < 0) return;
    rdata = cur_rsp_rdata;
    err   = cur_rsp_err;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ifc1.req_ready !== 1'b0 || ifc0.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_req_ready got %b/%b exp 0/0", ifc1.req_ready, ifc0.req_ready);
    end
    checks++;
    if (ifc1.rsp_valid !== 1'b0 || ifc1.rsp_rdata !== 32'h0 || ifc1.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got v=%b d=%h e=%b exp 0/0/0",
                         ifc1.rsp_valid, ifc1.rsp_rdata, ifc1.rsp_err);
    end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ifc1.req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready got %b exp 1", ifc1.req_ready);
    end
  endtask

`ifndef MEM_WRITE_PROTECT_EN
  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, d, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL write_rsp got lat=%0d e=%b d=%h exp 2/0/00000000", lat, e, d);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_after_write got lat=%0d e=%b d=%h exp 2/0/deadbeef", lat, e, d);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic e; int lat;
    xact(1'b1, 32'h20, 32'h1122_3344, 4'hF, d, e, lat);
    xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, d, e, lat);
    xact(1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (d !== 32'h11BB_33DD || e !== 1'b0) begin
      errors++; $display("FAIL byte_enable got d=%h e=%b exp 11bb33dd/0", d, e);
    end
    xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, d, e, lat);
    checks++;
    if (e !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL be_zero_rsp got e=%b lat=%0d exp 0/2", e, lat);
    end
    xact(1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (d !== 32'h11BB_33DD) begin
      errors++; $display("FAIL be_zero_nochange got %h exp 11bb33dd", d);
    end
  endtask
`else
  task automatic test_write_protect();
    logic [31:0] d; logic e; int lat;
    dut.u_mem.mem_q[0] = 32'h0000_0013;
    dut.u_mem.mem_q[8] = 32'h11BB_33DD;
    xact(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, d, e, lat);
    checks++;
    if (e !== 1'b1 || d !== 32'h0 || lat !== 2) begin
      errors++; $display("FAIL wp_write got e=%b d=%h lat=%0d exp 1/00000000/2", e, d, lat);
    end
    xact(1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (e !== 1'b0 || d !== 32'h0000_0013) begin
      errors++; $display("FAIL wp_read got e=%b d=%h exp 0/00000013", e, d);
    end
  endtask
`endif

  task automatic test_misalign_alias();
    logic [31:0] d; logic e; int lat;
    xact(1'b0, 32'h22, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (e !== 1'b1 || d !== 32'h0 || lat !== 2) begin
      errors++; $display("FAIL misaligned_read got e=%b d=%h lat=%0d exp 1/00000000/2", e, d, lat);
    end
    xact(1'b1, 32'h21, 32'h0BAD_0BAD, 4'hF, d, e, lat);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL misaligned_write got e=%b exp 1", e);
    end
    xact(1'b0, 32'h420, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (e !== 1'b0 || d !== 32'h11BB_33DD) begin
      errors++; $display("FAIL alias_read got e=%b d=%h exp 0/11bb33dd", e, d);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h20, 32'h0, 4'h0, ok);
    wait_rsp(lat);
    checks++;
    if (!ok || lat !== 2) begin
      errors++; $display("FAIL bp_latency got ok=%0d lat=%0d exp 1/2", ok, lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc1.rsp_valid !== 1'b1 || ifc1.rsp_rdata !== 32'h11BB_33DD ||
          ifc1.rsp_err !== 1'b0 || ifc1.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b rdy=%b exp 1/11bb33dd/0/0", i,
                           ifc1.rsp_valid, ifc1.rsp_rdata, ifc1.rsp_err, ifc1.req_ready);
      end
      @(posedge clk); @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ifc1.rsp_valid !== 1'b0 || ifc1.rsp_rdata !== 32'h0 || ifc1.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b d=%h rdy=%b exp 0/00000000/1",
                         ifc1.rsp_valid, ifc1.rsp_rdata, ifc1.req_ready);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] d; logic e; int lat;
    use_zw = 1'b1;
    xact(1'b0, 32'h42, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (lat !== 1 || e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL zw_misaligned got lat=%0d e=%b d=%h exp 1/1/00000000", lat, e, d);
    end
`ifndef MEM_WRITE_PROTECT_EN
    xact(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, d, e, lat);
    xact(1'b0, 32'h40, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (lat !== 1 || e !== 1'b0 || d !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL zw_read got lat=%0d e=%b d=%h exp 1/0/cafef00d", lat, e, d);
    end
`endif
    use_zw = 1'b0;
  endtask

`ifndef MEM_WRITE_PROTECT_EN
  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat; bit ok;
    issue(1'b1, 32'h30, 32'h5A5A_A5A5, 4'hF, ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || ifc1.rsp_valid !== 1'b0 || ifc1.req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_wait got ok=%0d v=%b rdy=%b exp 1/0/0",
                         ok, ifc1.rsp_valid, ifc1.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h30, 32'h0, 4'h0, ok);
    wait_rsp(lat);
    checks++;
    if (!ok || lat !== 2 || ifc1.rsp_rdata !== 32'h5A5A_A5A5) begin
      errors++; $display("FAIL rst_write_kept got ok=%0d lat=%0d d=%h exp 1/2/5a5aa5a5",
                         ok, lat, ifc1.rsp_rdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc1.rsp_valid !== 1'b0 || ifc1.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_in_resp got v=%b d=%h exp 0/00000000",
                         ifc1.rsp_valid, ifc1.rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ifc1.rsp_valid !== 1'b0 || ifc1.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_stale got v=%b rdy=%b exp 0/1", ifc1.rsp_valid, ifc1.req_ready);
    end
    xact(1'b0, 32'h30, 32'h0, 4'h0, d, e, lat);
    checks++;
    if (d !== 32'h5A5A_A5A5 || e !== 1'b0) begin
      errors++; $display("FAIL rst_read_back got d=%h e=%b exp 5a5aa5a5/0", d, e);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MEM_WRITE_PROTECT_EN
    test_write_protect();
`else
    test_write_read();
    test_byte_enable();
`endif
    test_misalign_alias();
    test_backpressure();
    test_zero_wait();
`ifndef MEM_WRITE_PROTECT_EN
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
